// File: rtl/or_unit_rr_arbiter_pkg.sv
// or_unit_rr_arbiter_pkg: shared FSM encodings and parameter defaults
package or_unit_rr_arbiter_pkg;
   localparam int N_DEF     = 4;
   localparam int IDW_DEF   = 2;
   localparam int CNT_W_DEF = 8;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;
endpackage

// File: rtl/or_unit_rr_arbiter_if.sv
// or_unit_rr_arbiter_if: requester-side bundle between requesters and the shared OR arbiter
interface or_unit_rr_arbiter_if
   import or_unit_rr_arbiter_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int IDW   = IDW_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic [N-1:0]     req;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic [N-1:0]     gnt;
   logic             y_valid;
   logic             y;
   logic [IDW-1:0]   y_id;
   logic             busy;
   logic [CNT_W-1:0] op_count;
   modport master (output req, a, b, input gnt, y_valid, y, y_id, busy, op_count);
   modport slave  (input req, a, b, output gnt, y_valid, y, y_id, busy, op_count);
endinterface

// File: rtl/or_unit_rr_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request after last, scanning upward modulo N
module rr_priority_pick
   import or_unit_rr_arbiter_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int IDW = IDW_DEF
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic           any,
   output logic [IDW-1:0] winner
);
   logic [IDW-1:0] idx;
   assign any = |req;
   // scanning from the far end lets the nearest candidate after last overwrite the others
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = IDW'((int'(last) + 1 + i) % N);
         if (req[idx]) winner = idx;
      end
   end
endmodule

// File: rtl/or_unit_rr_arbiter.sv
// or_unit_rr_arbiter: round-robin sharing of one OR unit, one grant and one tagged result per transaction
module or_unit_rr_arbiter
   import or_unit_rr_arbiter_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int IDW   = IDW_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic clk,
   input logic rst_n,
   or_unit_rr_arbiter_if.slave bus
);
   state_t           state;
   logic [IDW-1:0]   sel;
   logic [IDW-1:0]   last;
   logic [IDW-1:0]   winner;
   logic             any;
   logic [CNT_W-1:0] cnt;
   rr_priority_pick #(.N(N), .IDW(IDW)) u_pick (
      .req    (bus.req),
      .last   (last),
      .any    (any),
      .winner (winner)
   );
   assign bus.busy     = state != ST_IDLE;
   assign bus.op_count = cnt;
   // y/y_id double as the result registers, so they hold between pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         sel         <= '0;
         last        <= IDW'(N - 1);
         cnt         <= '0;
         bus.gnt     <= '0;
         bus.y_valid <= 1'b0;
         bus.y       <= 1'b0;
         bus.y_id    <= '0;
      end else begin
         bus.gnt     <= '0;
         bus.y_valid <= 1'b0;
         case (state)
            ST_IDLE: if (any) begin
               sel     <= winner;
               bus.gnt <= N'(1) << winner;
               state   <= ST_ISSUE;
            end
            ST_ISSUE: begin
               bus.y       <= bus.a[sel] | bus.b[sel];
               bus.y_id    <= sel;
               bus.y_valid <= 1'b1;
               last        <= sel;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               cnt   <= &cnt ? cnt : cnt + 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_or_unit_rr_arbiter.sv
// tb_or_unit_rr_arbiter: directed scoreboard bench, default build plus a 2-bit counter build
module tb_or_unit_rr_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   or_unit_rr_arbiter_if #(.N(4), .IDW(2), .CNT_W(8)) bus ();
   or_unit_rr_arbiter_if #(.N(4), .IDW(2), .CNT_W(2)) bus_s ();
   assign bus_s.req = bus.req;
   assign bus_s.a   = bus.a;
   assign bus_s.b   = bus.b;
   or_unit_rr_arbiter #(.N(4), .IDW(2), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   or_unit_rr_arbiter #(.N(4), .IDW(2), .CNT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
   typedef struct packed {
      logic [1:0] id;
      logic       y;
   } exp_t;
   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   model_cnt = 0;
   bit   inc_pend = 1'b0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask
   // one clock step; afterwards the scoreboard and counter model are checked
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      if (inc_pend) model_cnt++;
      inc_pend = 1'b0;
      chk("op_count", 32'(bus.op_count), (model_cnt > 255) ? 255 : model_cnt);
      chk("op_count_sat", 32'(bus_s.op_count), (model_cnt > 3) ? 3 : model_cnt);
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
      if (bus.y_valid) begin
         if (q.size() == 0) chk("unexpected_y_valid", 32'(bus.y_valid), 0);
         else begin
            e = q.pop_front();
            chk("y", 32'(bus.y), 32'(e.y));
            chk("y_id", 32'(bus.y_id), 32'(e.id));
            inc_pend = 1'b1;
         end
      end
   endtask
   task automatic op(input logic [3:0] r, input logic [3:0] av, input logic [3:0] bv,
                     input logic [1:0] id, input logic [3:0] nr);
      exp_t e;
      bus.req = r;
      bus.a   = av;
      bus.b   = bv;
      e.id = id;
      e.y  = av[id] | bv[id];
      q.push_back(e);
      cyc();
      chk("gnt", 32'(bus.gnt), 32'(4'b0001 << id));
      chk("busy_issue", 32'(bus.busy), 1);
      chk("y_valid_issue", 32'(bus.y_valid), 0);
      bus.req = nr;
      cyc();
      chk("y_valid_resp", 32'(bus.y_valid), 1);
      chk("gnt_resp", 32'(bus.gnt), 0);
      cyc();
      chk("busy_idle", 32'(bus.busy), 0);
      chk("y_valid_idle", 32'(bus.y_valid), 0);
   endtask
   initial begin
      rst_n   = 1'b0;
      bus.req = '0;
      bus.a   = '0;
      bus.b   = '0;
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (10) begin
         cyc();
         chk("idle_gnt", 32'(bus.gnt), 0);
         chk("idle_y_valid", 32'(bus.y_valid), 0);
         chk("idle_y", 32'(bus.y), 0);
         chk("idle_y_id", 32'(bus.y_id), 0);
         chk("idle_busy", 32'(bus.busy), 0);
      end
      op(4'b1111, 4'b0101, 4'b0000, 2'd0, 4'b1111);
      op(4'b1111, 4'b0101, 4'b0000, 2'd1, 4'b1111);
      op(4'b1111, 4'b0101, 4'b0000, 2'd2, 4'b1111);
      op(4'b1111, 4'b0101, 4'b0000, 2'd3, 4'b1111);
      op(4'b1111, 4'b0101, 4'b0000, 2'd0, 4'b1111);
      bus.req = '0;
      op(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'b0000);
      chk("op_count_single", 32'(bus.op_count), 6);
      op(4'b0010, 4'b0010, 4'b0000, 2'd1, 4'b0000);
      op(4'b0011, 4'b0000, 4'b0000, 2'd0, 4'b0010);
      op(4'b0010, 4'b0000, 4'b0010, 2'd1, 4'b0000);
      cyc();
      chk("y_hold", 32'(bus.y), 1);
      chk("y_id_hold", 32'(bus.y_id), 1);
      bus.req = 4'b0100;
      cyc();
      chk("gnt_before_abort", 32'(bus.gnt), 32'(4'b0100));
      rst_n = 1'b0;
      bus.req = '0;
      q.delete();
      model_cnt = 0;
      inc_pend = 1'b0;
      #1;
      chk("abort_gnt", 32'(bus.gnt), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_op_count", 32'(bus.op_count), 0);
      chk("abort_y_valid", 32'(bus.y_valid), 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      op(4'b1111, 4'b0001, 4'b0000, 2'd0, 4'b0000);
      op(4'b0001, 4'b0000, 4'b0000, 2'd0, 4'b0000);
      op(4'b0001, 4'b0001, 4'b0001, 2'd0, 4'b0000);
      op(4'b0001, 4'b0000, 4'b0001, 2'd0, 4'b0000);
      op(4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0000);
      chk("sat_small", 32'(bus_s.op_count), 3);
      for (int k = 0; k < 256; k++)
         op(4'b1000, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'd3, 4'b0000);
      chk("sat_full", 32'(bus.op_count), 255);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
